// File: rtl/btc_job_pkg.sv
// Shared types for the bitcoin job controller: FSM states and the scan result record.
package btc_job_pkg;
  localparam int NUM_MSG_WORDS = 20;
  localparam int NUM_NONCES    = 16;

  typedef enum logic [2:0] {
    IDLE, LOAD, KICK, WAIT_BUSY, WAIT_DONE, SCAN, REPORT
  } state_e;

  typedef struct packed {
    logic        found;
    logic [3:0]  nonce;
    logic [31:0] hash;
    logic        timeout;
  } btc_res_t;
endpackage

// File: rtl/btc_word_ram.sv
// Single-port word RAM shared by the job controller and the hasher; registered read.
module btc_word_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= wdata_i;

  // Only the read register is reset; array contents start undefined.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= mem_q[addr_i];

  assign rdata_o = rdata_q;
endmodule

// File: rtl/bitcoin_job_ctrl.sv
// Loads a 20-word header into the shared RAM, kicks the hasher, then scans its 16 h0
// results for the first one below target. Optional watchdog: define BTC_JOB_WDOG_EN.
module bitcoin_job_ctrl
  import btc_job_pkg::*;
#(
  parameter int          ADDR_W      = 6,
  parameter logic [15:0] MSG_BASE    = 16'h0000,
  parameter logic [15:0] OUT_BASE    = 16'h0020,
  parameter int          NUM_NONCES  = 16,
  parameter int          WDOG_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_word,
  input  logic [31:0] job_target,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_found,
  output logic [3:0]  res_nonce,
  output logic [31:0] res_hash,
  output logic        res_timeout,
  output logic        busy,
  output logic        addr_err,
  output logic        hash_start,
  input  logic        hash_done,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic        mem_clk,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data
);
  localparam int SCAN_W = $clog2(NUM_NONCES + 1);

  state_e            state_q, state_d;
  logic [4:0]        beat_q, beat_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [31:0]       target_q, target_d;
  btc_res_t          res_q, res_d;
  logic              addr_err_q, oor_q;
  logic              ctl_we, ram_we, hasher_own, addr_hi, scan_hit;
  logic [15:0]       ctl_addr;
  logic [3:0]        scan_j;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

`ifdef BTC_JOB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    scan_d   = scan_q;
    target_d = target_q;
    res_d    = res_q;
    ctl_we   = 1'b0;
    ctl_addr = MSG_BASE + 16'(beat_q);
    scan_j   = 4'(scan_q - 1'b1);
    scan_hit = ram_rdata < target_q;
    case (state_q)
      IDLE: if (job_valid) begin
        ctl_we   = 1'b1;
        ctl_addr = MSG_BASE;
        target_d = job_target;
        beat_d   = 5'd1;
        state_d  = LOAD;
      end
      LOAD: if (job_valid) begin
        ctl_we = 1'b1;
        if (beat_q == 5'(NUM_MSG_WORDS - 1)) state_d = KICK;
        else                                  beat_d  = beat_q + 5'd1;
      end
      KICK: begin
        res_d   = '0;
        scan_d  = '0;
        state_d = WAIT_BUSY;
      end
      // done is high before the hasher starts, so it must be seen low first
      WAIT_BUSY: if (!hash_done) state_d = WAIT_DONE;
      WAIT_DONE: if (hash_done)  state_d = SCAN;
      SCAN: begin
        ctl_addr = OUT_BASE + 16'(scan_q);
        scan_d   = scan_q + 1'b1;
        // Data for word j lands one cycle after its address; strict < keeps the lower j on ties.
        if (scan_q == SCAN_W'(1) ||
            (scan_q != '0 && !res_q.found && (scan_hit || ram_rdata < res_q.hash))) begin
          res_d.found = scan_hit;
          res_d.nonce = scan_j;
          res_d.hash  = ram_rdata;
        end
        if (scan_q == SCAN_W'(NUM_NONCES)) state_d = REPORT;
      end
      REPORT: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef BTC_JOB_WDOG_EN
    wdog_d = '0;
    if (state_q == WAIT_BUSY || state_q == WAIT_DONE) begin
      wdog_d = wdog_q + 1'b1;
      if (state_d != SCAN && wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
        state_d       = REPORT;
        res_d         = '0;
        res_d.timeout = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      scan_q     <= '0;
      target_q   <= '0;
      res_q      <= '0;
      addr_err_q <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      scan_q     <= scan_d;
      target_q   <= target_d;
      res_q      <= res_d;
      addr_err_q <= addr_err_q | (hasher_own & addr_hi);
      oor_q      <= hasher_own & addr_hi;
    end

`ifdef BTC_JOB_WDOG_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) wdog_q <= '0;
    else          wdog_q <= wdog_d;
`endif

  // Hasher writes outside its window are dropped: it holds mem_we high while idle.
  assign hasher_own = (state_q == KICK) || (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);
  assign addr_hi    = |mem_addr[15:ADDR_W];
  assign ram_we     = hasher_own ? (mem_we & ~addr_hi) : ctl_we;
  assign ram_addr   = hasher_own ? mem_addr[ADDR_W-1:0] : ctl_addr[ADDR_W-1:0];
  assign ram_wdata  = hasher_own ? mem_write_data : job_word;

  btc_word_ram #(.ADDR_W(ADDR_W), .DATA_W(32)) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign mem_read_data = oor_q ? 32'h0 : ram_rdata;
  assign job_ready     = (state_q == IDLE) || (state_q == LOAD);
  assign hash_start    = (state_q == KICK);
  assign busy          = (state_q != IDLE);
  assign res_valid     = (state_q == REPORT);
  assign res_found     = res_q.found;
  assign res_nonce     = res_q.nonce;
  assign res_hash      = res_q.hash;
  assign addr_err      = addr_err_q;
  assign message_addr  = MSG_BASE;
  assign output_addr   = OUT_BASE;

`ifdef BTC_JOB_WDOG_EN
  assign res_timeout = res_q.timeout;
`else
  assign res_timeout = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{mem_clk, ctl_addr[15:ADDR_W], res_q.timeout};
endmodule
